trunc_narrow_stage: RTL

Streaming width-narrowing stage that accepts IN_W-bit unsigned beats over a valid/ready handshake and emits OUT_W-bit beats, either truncating or saturating each one. Every beat whose discarded high bits are nonzero is flagged, counted and recorded in a sticky bit. It sits directly upstream of any narrower consumer: it makes explicit, and observable, the narrowing that a plain assignment from a wider to a narrower net would perform silently. Beats pass through a 2-entry skid buffer, so the stage sustains full throughput with registered backpressure.

---
 rtl/trunc_narrow_stage.sv | 97 +++++++++
 1 files changed

// File: rtl/trunc_narrow_stage.sv
// Width-narrowing stream stage: truncates or saturates IN_W-bit beats to OUT_W bits,
// flags lossy beats, and buffers through a 2-entry skid FIFO with registered ready.
module trunc_narrow_stage #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             sat_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_lost,
    output logic [CNT_W-1:0] trunc_cnt,
    output logic             trunc_sticky
);

    // Buffer entry: {lost, data}
    typedef struct packed {
        logic             lost;
        logic [OUT_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state;
    entry_t head, tail, incoming;
    logic   accept, emit;

    always_comb begin
        incoming      = '0;
        incoming.lost = |in_data[IN_W-1:OUT_W];
        incoming.data = (sat_en && incoming.lost) ? {OUT_W{1'b1}} : in_data[OUT_W-1:0];
    end

    // Ready and valid come straight from registered state, never from out_ready.
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;
    assign out_data  = head.data;
    assign out_lost  = head.lost;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            unique case (state)
                EMPTY: if (accept) begin
                    head  <= incoming;
                    state <= ONE;
                end
                ONE: begin
                    if (accept && emit) begin
                        head <= incoming;
                    end else if (accept) begin
                        tail  <= incoming;
                        state <= TWO;
                    end else if (emit) begin
                        state <= EMPTY;
                    end
                end
                TWO: if (emit) begin
                    head  <= tail;
                    state <= ONE;
                end
                default: state <= EMPTY;
            endcase
        end
    end

    logic lossy_acc;
    assign lossy_acc = accept && incoming.lost;

    // A lossy beat landing with clr still counts, so the event is never dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trunc_cnt    <= '0;
            trunc_sticky <= 1'b0;
        end else if (clr) begin
            trunc_cnt    <= lossy_acc ? CNT_W'(1) : '0;
            trunc_sticky <= lossy_acc;
        end else if (lossy_acc) begin
            if (trunc_cnt != {CNT_W{1'b1}})
                trunc_cnt <= trunc_cnt + CNT_W'(1);
            trunc_sticky <= 1'b1;
        end
    end

endmodule
